// File: rtl/data_mem_pkg.sv
// Shared definitions for the pipelined load/store data memory.
package data_mem_pkg;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;

  // Per-byte merge; callers apply it across every byte lane of a word.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/data_mem_rsp_fifo.sv
// Synchronous response FIFO; any depth, head visible combinationally on pop_data.
module data_mem_rsp_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | pop);
  assign pop_data = store[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= push_data;
        wr_ptr        <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Pipelined data memory: valid/ready requests, byte-enabled writes, configurable
// read latency and a credit-protected response FIFO.
module data_mem_pipe
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DEPTH     = 65536,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned RSP_DEPTH = RD_LAT + 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                wr_err
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CRD_W = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
  } rsp_t;

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("data_mem_pipe: RD_LAT must be within 1..4");
  end
  if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("data_mem_pipe: DATA_W must be a non-zero multiple of 8");
  end
  if (DEPTH == 0 || 64'(DEPTH) > (64'(1) << ADDR_W)) begin : g_bad_depth
    $error("data_mem_pipe: DEPTH must be within 1..2**ADDR_W");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] mem_q, merged;
  logic              in_range, accept, rd_acc, wr_acc, deq;
  logic [CRD_W-1:0]  outstanding;
  rsp_t              rd_pay, enq_pay, head;
  logic              enq_valid;
  logic              fifo_full, fifo_empty;
  logic [CRD_W-1:0]  fifo_count;

  assign in_range  = ({1'b0, req_addr} < (ADDR_W + 1)'(DEPTH));
  assign idx       = req_addr[IDX_W-1:0];
  assign req_ready = (outstanding < CRD_W'(RSP_DEPTH));
  assign accept    = req_valid & req_ready;
  assign rd_acc    = accept & ~req_wr;
  assign wr_acc    = accept & req_wr & in_range;
  assign deq       = rsp_valid & rsp_ready;

  assign mem_q = mem[idx];

  always_comb begin
    merged = mem_q;
    for (int unsigned i = 0; i < BE_W; i++)
      merged[8*i +: 8] = byte_merge(mem_q[8*i +: 8], req_wdata[8*i +: 8], req_be[i]);
  end

  always_ff @(posedge CLK) begin
    if (wr_acc) mem[idx] <= merged;
  end

  assign rd_pay.data = in_range ? mem_q : '0;
  assign rd_pay.err  = ~in_range;

  // The FIFO write is the last latency stage, so only RD_LAT-1 registers sit in front of it.
  if (RD_LAT == 1) begin : g_lat1
    assign enq_valid = rd_acc;
    assign enq_pay   = rd_pay;
  end else begin : g_pipe
    logic [RD_LAT-2:0] stg_valid;
    rsp_t              stg_pay [RD_LAT-1];

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        stg_valid <= '0;
        for (int unsigned i = 0; i < RD_LAT - 1; i++) stg_pay[i] <= '0;
      end else begin
        stg_valid[0] <= rd_acc;
        stg_pay[0]   <= rd_pay;
        for (int unsigned i = 1; i < RD_LAT - 1; i++) begin
          stg_valid[i] <= stg_valid[i-1];
          stg_pay[i]   <= stg_pay[i-1];
        end
      end
    end

    assign enq_valid = stg_valid[RD_LAT-2];
    assign enq_pay   = stg_pay[RD_LAT-2];
  end

  data_mem_rsp_fifo #(
    .WIDTH ($bits(rsp_t)),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .CLK       (CLK),
    .RST       (RST),
    .push      (enq_valid),
    .push_data (enq_pay),
    .pop       (deq),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_data  = head.data;
  assign rsp_err   = head.err;

  // Credits cover FIFO entries plus reads still in the pipeline.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      outstanding <= '0;
      wr_err      <= 1'b0;
    end else begin
      if (rd_acc && !deq)      outstanding <= outstanding + 1'b1;
      else if (!rd_acc && deq) outstanding <= outstanding - 1'b1;
      wr_err <= accept & req_wr & ~in_range;
    end
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    !(enq_valid && fifo_full && !deq));
  a_credit_cover: assert property (@(posedge CLK) disable iff (RST)
    fifo_count <= outstanding);

endmodule

// File: tb/tb_data_mem_pipe.sv
// Scoreboard bench for data_mem_pipe: reads push expected data at accept, dequeues pop and compare.
module tb_data_mem_pipe;

  localparam int DW        = 16;
  localparam int AW        = 16;
  localparam int DEPTH     = 1024;
  localparam int RD_LAT    = 2;
  localparam int RSP_DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_be;
  logic          rsp_valid, rsp_ready, rsp_err, wr_err;
  logic [DW-1:0] rsp_data;

  data_mem_pipe #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DEPTH     (DEPTH),
    .RD_LAT    (RD_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .CLK       (clk),
    .RST       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            t;
  } exp_t;

  typedef struct {
    bit            wr;
    int            a;
    logic [DW-1:0] d;
    logic [1:0]    be;
  } req_t;

  exp_t          sbq[$];
  logic [DW-1:0] mdl [DEPTH];
  int            cyc    = 0;
  int            n_chk  = 0;
  int            n_pass = 0;

  task automatic drive(input bit v, input bit wr, input int a, input logic [DW-1:0] d,
                       input logic [1:0] be);
    req_valid = v;
    req_wr    = wr;
    req_addr  = AW'(a);
    req_wdata = d;
    req_be    = be;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 0, '0, 2'b00);
  endtask

  // Models one clock edge from the currently driven inputs, then returns 1 time unit after it.
  task automatic tick(output bit acc, output bit deq, output exp_t got, output exp_t want);
    exp_t ne;
    acc = (req_valid === 1'b1) && (req_ready === 1'b1);
    deq = (rsp_valid === 1'b1) && (rsp_ready === 1'b1);
    got.d  = rsp_data;
    got.e  = rsp_err;
    got.t  = cyc;
    want.d = 'x;
    want.e = 1'bx;
    want.t = -1;
    if (deq && sbq.size() != 0) want = sbq.pop_front();
    if (acc && !req_wr) begin
      ne.e = (req_addr >= DEPTH);
      ne.d = ne.e ? '0 : mdl[req_addr];
      ne.t = cyc;
      sbq.push_back(ne);
    end
    if (acc && req_wr && req_addr < DEPTH)
      for (int i = 0; i < DW / 8; i++)
        if (req_be[i]) mdl[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    idle();
    rsp_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b want 1", req_ready); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); else n_pass++;
    n_chk++; if (rsp_data !== '0) $display("FAIL rst_rsp_data: got %h want 0000", rsp_data); else n_pass++;
    n_chk++; if (rsp_err !== 1'b0) $display("FAIL rst_rsp_err: got %b want 0", rsp_err); else n_pass++;
    n_chk++; if (wr_err !== 1'b0) $display("FAIL rst_wr_err: got %b want 0", wr_err); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_byte_enable();
    req_t          rq [3];
    int            k = 0;
    bit            acc, deq;
    exp_t          got, want;
    logic [DW-1:0] last = '0;
    rq[0] = '{1'b1, 5, 16'hABCD, 2'b11};
    rq[1] = '{1'b1, 5, 16'h1234, 2'b01};
    rq[2] = '{1'b0, 5, 16'h0000, 2'b00};
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && (k < 3 || sbq.size() != 0); c++) begin
      if (k < 3) drive(1'b1, rq[k].wr, rq[k].a, rq[k].d, rq[k].be); else idle();
      tick(acc, deq, got, want);
      if (acc) k++;
      if (deq) begin
        last = got.d;
        n_chk++; if (got.d !== want.d || got.e !== want.e)
          $display("FAIL be_rsp: got %h/%b want %h/%b", got.d, got.e, want.d, want.e); else n_pass++;
        n_chk++; if (got.t - want.t != RD_LAT)
          $display("FAIL be_latency: got %0d want %0d", got.t - want.t, RD_LAT); else n_pass++;
      end
    end
    idle();
    n_chk++; if (k != 3 || sbq.size() != 0)
      $display("FAIL be_done: accepted %0d pending %0d want 3/0", k, sbq.size()); else n_pass++;
    n_chk++; if (last !== 16'hAB34) $display("FAIL be_value: got %h want ab34", last); else n_pass++;
  endtask

  task automatic test_back_to_back();
    req_t          rq [4];
    int            k = 0;
    bit            acc, deq;
    exp_t          got, want;
    logic [DW-1:0] seen[$];
    rq[0] = '{1'b1, 7, 16'h0001, 2'b11};
    rq[1] = '{1'b0, 7, 16'h0000, 2'b00};
    rq[2] = '{1'b1, 7, 16'h0002, 2'b11};
    rq[3] = '{1'b0, 7, 16'h0000, 2'b00};
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && (k < 4 || sbq.size() != 0); c++) begin
      if (k < 4) begin
        drive(1'b1, rq[k].wr, rq[k].a, rq[k].d, rq[k].be);
        n_chk++; if (req_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1 at req %0d", req_ready, k); else n_pass++;
      end else idle();
      tick(acc, deq, got, want);
      if (acc) k++;
      if (deq) begin
        seen.push_back(got.d);
        n_chk++; if (got.d !== want.d || got.e !== want.e)
          $display("FAIL b2b_rsp: got %h/%b want %h/%b", got.d, got.e, want.d, want.e); else n_pass++;
        n_chk++; if (got.t - want.t != RD_LAT)
          $display("FAIL b2b_latency: got %0d want %0d", got.t - want.t, RD_LAT); else n_pass++;
      end
    end
    idle();
    n_chk++; if (seen.size() != 2) $display("FAIL b2b_count: got %0d want 2", seen.size());
    else if (seen[0] !== 16'h0001 || seen[1] !== 16'h0002)
      $display("FAIL b2b_order: got %h,%h want 0001,0002", seen[0], seen[1]);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int   k = 0;
    bit   acc, deq, first = 1'b0;
    exp_t got, want;
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 20 + i, DW'(16'h2000 + i), 2'b11);
      tick(acc, deq, got, want);
      n_chk++; if (!acc) $display("FAIL bp_prewrite: got 0 want 1 accept at %0d", i); else n_pass++;
    end
    rsp_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (k < 5) drive(1'b1, 1'b0, 20 + k, '0, 2'b00); else idle();
      tick(acc, deq, got, want);
      if (acc) k++;
    end
    n_chk++; if (k != RSP_DEPTH) $display("FAIL bp_accepted: got %0d want %0d", k, RSP_DEPTH); else n_pass++;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL bp_ready_low: got %b want 0", req_ready); else n_pass++;
    n_chk++; if (rsp_valid !== 1'b1 || rsp_data !== sbq[0].d)
      $display("FAIL bp_head_hold: got %b/%h want 1/%h", rsp_valid, rsp_data, sbq[0].d); else n_pass++;
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && (k < 5 || sbq.size() != 0); c++) begin
      if (k < 5) drive(1'b1, 1'b0, 20 + k, '0, 2'b00); else idle();
      tick(acc, deq, got, want);
      if (acc) k++;
      if (deq) begin
        n_chk++; if (got.d !== want.d || got.e !== want.e)
          $display("FAIL bp_rsp: got %h/%b want %h/%b", got.d, got.e, want.d, want.e); else n_pass++;
        if (!first) begin
          first = 1'b1;
          n_chk++; if (req_ready !== 1'b1) $display("FAIL bp_recover: got %b want 1", req_ready); else n_pass++;
        end
      end
    end
    idle();
    n_chk++; if (k != 5 || sbq.size() != 0)
      $display("FAIL bp_done: accepted %0d pending %0d want 5/0", k, sbq.size()); else n_pass++;
  endtask

  task automatic test_out_of_range();
    req_t rq [4];
    int   k = 0;
    bit   acc, deq, werr_exp;
    exp_t got, want;
    int   n_err = 0;
    rq[0] = '{1'b1, 0,     16'h5A5A, 2'b11};
    rq[1] = '{1'b1, DEPTH, 16'hFFFF, 2'b11};
    rq[2] = '{1'b0, DEPTH, 16'h0000, 2'b00};
    rq[3] = '{1'b0, 0,     16'h0000, 2'b00};
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && (k < 4 || sbq.size() != 0); c++) begin
      if (k < 4) drive(1'b1, rq[k].wr, rq[k].a, rq[k].d, rq[k].be); else idle();
      werr_exp = (req_valid === 1'b1) && (req_ready === 1'b1) && req_wr && (req_addr >= DEPTH);
      tick(acc, deq, got, want);
      if (acc) k++;
      n_chk++; if (wr_err !== werr_exp) $display("FAIL oor_wr_err: got %b want %b", wr_err, werr_exp); else n_pass++;
      if (deq) begin
        if (got.e === 1'b1) n_err++;
        n_chk++; if (got.d !== want.d || got.e !== want.e)
          $display("FAIL oor_rsp: got %h/%b want %h/%b", got.d, got.e, want.d, want.e); else n_pass++;
      end
    end
    idle();
    n_chk++; if (n_err != 1) $display("FAIL oor_err_count: got %0d want 1", n_err); else n_pass++;
  endtask

  task automatic test_reset_midburst();
    bit   acc, deq;
    exp_t got, want;
    rsp_ready = 1'b1;
    drive(1'b1, 1'b1, 30, 16'hC0DE, 2'b11);
    tick(acc, deq, got, want);
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b0, 30, '0, 2'b00);
      tick(acc, deq, got, want);
      n_chk++; if (!acc) $display("FAIL rmb_accept: got 0 want 1 for read %0d", i); else n_pass++;
    end
    idle();
    n_chk++; if (rsp_valid !== 1'b1) $display("FAIL rmb_pre_valid: got %b want 1", rsp_valid); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_chk++; if (rsp_valid !== 1'b0) $display("FAIL rmb_valid_drop: got %b want 0", rsp_valid); else n_pass++;
    n_chk++; if (req_ready !== 1'b1 || rsp_data !== '0)
      $display("FAIL rmb_reset_state: got %b/%h want 1/0000", req_ready, rsp_data); else n_pass++;
    sbq.delete();
    #1 rst = 1'b0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(acc, deq, got, want);
      n_chk++; if (deq) $display("FAIL rmb_ghost: got response %h want none", got.d); else n_pass++;
    end
    drive(1'b1, 1'b0, 30, '0, 2'b00);
    tick(acc, deq, got, want);
    idle();
    for (int c = 0; c < 10 && sbq.size() != 0; c++) begin
      tick(acc, deq, got, want);
      if (deq) begin
        n_chk++; if (got.d !== 16'hC0DE || got.e !== 1'b0 || got.d !== want.d)
          $display("FAIL rmb_persist: got %h/%b want c0de/0", got.d, got.e); else n_pass++;
      end
    end
    n_chk++; if (sbq.size() != 0) $display("FAIL rmb_done: pending %0d want 0", sbq.size()); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_back_to_back();
    test_backpressure();
    test_out_of_range();
    test_reset_midburst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
